alus_serial: RTL and testbench

- Multi-cycle, bit-serial counterpart of the Gumnut combinational shift unit.
- Performs shl, shr, rol and ror one bit position per clock, under a start/done handshake.
- Intended for area-reduced core builds and as a cycle-accurate reference engine for shift-unit verification.
- Results (res, cout) match the combinational shift unit for every rs_i/ALUOp_i/count_i combination.

---
 rtl/alus_serial.sv | 143 ++++++++++++++
 tb/tb_alus_serial.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alus_serial.sv
// alus_serial: bit-serial shift engine that moves one bit position per clock.
// Produces the same res/cout as the combinational shl/shr/rol/ror unit.
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for start_i
//   ST_SHIFT | one bit step per edge, cnt_q counts down to zero
//   ST_DONE  | res/cout valid and updated, done_o high for this one cycle
//
// Ports
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   request, accepted in ST_IDLE or ST_DONE
//   rs_i      source operand, latched on accept
//   ALUOp_i   00 shl, 01 shr, 10 rol, 11 ror, latched on accept
//   count_i   shift amount, latched on accept
//   busy_o    high in ST_SHIFT
//   done_o    high in ST_DONE
//   res       registered result
//   cout      registered carry out
module alus_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               cout_q, cout_d;

  // One bit step applied to the working register.
  logic [WIDTH-1:0]   w_step;
  logic               c_step;

  always_comb begin
    w_step = w_q;
    c_step = 1'b0;
    case (op_q)
      2'b00: begin
        c_step = w_q[WIDTH-1];
        w_step = {w_q[WIDTH-2:0], 1'b0};
      end
      2'b01: begin
        c_step = w_q[0];
        w_step = {1'b0, w_q[WIDTH-1:1]};
      end
      2'b10: begin
        w_step = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
      end
      default: begin
        w_step = {w_q[0], w_q[WIDTH-1:1]};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    res_d   = res_q;
    cout_d  = cout_q;

    case (state_q)
      ST_SHIFT: begin
        w_d   = w_step;
        c_d   = c_step;
        cnt_d = cnt_q - CNT_W'(1);
        // Terminal count: this step is the last one, publish it now.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          res_d   = w_step;
          cout_d  = c_step;
        end
      end
      default: begin
        if (start_i) begin
          w_d   = rs_i;
          op_d  = ALUOp_i;
          cnt_d = count_i;
          c_d   = 1'b0;
          if (count_i == '0) begin
            // Zero shift skips ST_SHIFT; result is the operand, no carry.
            state_d = ST_DONE;
            res_d   = rs_i;
            cout_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  assign busy_o = (state_q == ST_SHIFT);
  assign done_o = (state_q == ST_DONE);
  assign res    = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_alus_serial.sv
module tb_alus_serial;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] rs_i;
  logic [1:0] ALUOp_i;
  logic [2:0] count_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] res;
  logic       cout;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  alus_serial #(.WIDTH(8), .CNT_W(3)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .rs_i    (rs_i),
    .ALUOp_i (ALUOp_i),
    .count_i (count_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .res     (res),
    .cout    (cout)
  );

  typedef struct {
    logic [7:0] rs;
    logic [1:0] op;
    logic [2:0] n;
    logic [7:0] exp_res;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: whole-word arithmetic on the shift amount, no stepping.
  function automatic int ref_shift(input int rs, input int op, input int n);
    int r, c;
    r = 0; c = 0;
    case (op)
      0: begin r = (rs << n) & 8'hFF; c = (n == 0) ? 0 : (rs >> (8 - n)) & 1; end
      1: begin r = rs >> n;           c = (n == 0) ? 0 : (rs >> (n - 1)) & 1; end
      2: r = ((rs << n) | (rs >> (8 - n))) & 8'hFF;
      default: r = ((rs >> n) | (rs << (8 - n))) & 8'hFF;
    endcase
    return (c << 8) | r;
  endfunction

  // Starts an op at the current negedge and returns at the negedge where done_o is seen.
  task automatic run_op(input logic [7:0] rs, input logic [1:0] op, input logic [2:0] n,
                        output logic [7:0] r, output logic c, output int lat, output int bz);
    rs_i = rs; ALUOp_i = op; count_i = n; start_i = 1'b1;
    lat = 0; bz = 0;
    @(negedge clk_i);
    start_i = 1'b0;
    rs_i = 8'($urandom); ALUOp_i = 2'($urandom); count_i = 3'($urandom);
    lat = 1;
    while (!done_o && lat < 20) begin
      if (busy_o) bz++;
      @(negedge clk_i);
      lat++;
    end
    if (!done_o) begin
      total_cnt++;
      $display("FAIL done_timeout: got no done_o after %0d cycles, expected done", lat);
    end
    r = res; c = cout;
  endtask

  initial begin
    logic [7:0] r;
    logic       c;
    int         lat, bz, e, gap;

    vecs[0] = '{8'h81, 2'b00, 3'd1, 8'h02, 1'b1};
    vecs[1] = '{8'h81, 2'b01, 3'd3, 8'h10, 1'b0};
    vecs[2] = '{8'h81, 2'b10, 3'd4, 8'h18, 1'b0};
    vecs[3] = '{8'h01, 2'b11, 3'd1, 8'h80, 1'b0};
    vecs[4] = '{8'hB4, 2'b00, 3'd0, 8'hB4, 1'b0};
    vecs[5] = '{8'hB4, 2'b01, 3'd2, 8'h2D, 1'b0};
    vecs[6] = '{8'hFF, 2'b00, 3'd7, 8'h80, 1'b1};
    vecs[7] = '{8'h01, 2'b01, 3'd1, 8'h00, 1'b1};
    vecs[8] = '{8'h80, 2'b10, 3'd1, 8'h01, 1'b0};
    vecs[9] = '{8'hF0, 2'b11, 3'd7, 8'hE1, 1'b0};

    rst_i = 1'b1; start_i = 1'b0; rs_i = 8'h00; ALUOp_i = 2'b00; count_i = 3'd0;
    repeat (3) @(negedge clk_i);
    chk("reset_res", res, 0);
    chk("reset_cout", cout, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table vectors, issued back-to-back (each start lands in DONE of the previous op).
    foreach (vecs[i]) begin
      run_op(vecs[i].rs, vecs[i].op, vecs[i].n, r, c, lat, bz);
      chk($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_cout", i), c, vecs[i].exp_cout);
      chk($sformatf("vec%0d_latency", i), lat, int'(vecs[i].n) + 1);
      chk($sformatf("vec%0d_busy_cycles", i), bz, int'(vecs[i].n));
      chk($sformatf("vec%0d_busy_in_done", i), busy_o, 0);
    end

    // DONE without start returns to IDLE; result held.
    @(negedge clk_i);
    chk("idle_done", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_res_hold", res, 8'hE1);

    // Start pulsed during SHIFT is ignored.
    rs_i = 8'hFF; ALUOp_i = 2'b00; count_i = 3'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("shift_res_hold", res, 8'hE1);
    rs_i = 8'h00; ALUOp_i = 2'b01; count_i = 3'd1; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 3;
    while (!done_o && lat < 20) begin @(negedge clk_i); lat++; end
    chk("ignore_latency", lat, 8);
    chk("ignore_res", res, 8'h80);
    chk("ignore_cout", cout, 1);
    @(negedge clk_i);

    // Reset on the 3rd SHIFT cycle aborts the op.
    rs_i = 8'hFF; ALUOp_i = 2'b00; count_i = 3'd7; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("abort_busy_before", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_res", res, 0);
    chk("abort_cout", cout, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    e = 0;
    repeat (10) begin @(negedge clk_i); if (done_o || busy_o) e++; end
    chk("abort_no_done", e, 0);

    // Exhaustive against the reference model.
    e = 0;
    for (int op = 0; op < 4; op++)
      for (int n = 0; n < 8; n++)
        for (int v = 0; v < 256; v++) begin
          run_op(8'(v), 2'(op), 3'(n), r, c, lat, bz);
          if (((int'(c) << 8) | int'(r)) != ref_shift(v, op, n) || lat != n + 1) begin
            e++;
            if (e <= 5)
              $display("FAIL exhaustive op=%0d n=%0d rs=0x%0h: got cout=%0d res=0x%0h lat=%0d expected 0x%0h lat=%0d",
                       op, n, v, c, r, lat, ref_shift(v, op, n), n + 1);
          end
        end
    chk("exhaustive_errors", e, 0);

    // Random ops with random idle gaps.
    for (int k = 0; k < 300; k++) begin
      int v, op, n, x;
      v = int'($urandom_range(255)); op = int'($urandom_range(3)); n = int'($urandom_range(7));
      run_op(8'(v), 2'(op), 3'(n), r, c, lat, bz);
      x = ref_shift(v, op, n);
      chk($sformatf("rand%0d", k), (int'(c) << 8) | int'(r), x);
      gap = int'($urandom_range(2));
      repeat (gap) @(negedge clk_i);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
